// File: rtl/dual_issue_steer_unit_pkg.sv
// Shared encodings for the dual-issue steer unit: opcode fields, opcode constants,
// register-role masks, instruction classes and controller states.
package dual_issue_steer_unit_pkg;

  localparam int unsigned OPC_W = 6;

  localparam logic [OPC_W-1:0] OPC_LW    = 6'b100000;
  localparam logic [OPC_W-1:0] OPC_SW    = 6'b100001;
  localparam logic [OPC_W-1:0] OPC_LA    = 6'b100010;
  localparam logic [OPC_W-1:0] OPC_SA    = 6'b100011;
  localparam logic [OPC_W-1:0] OPC_JR    = 6'b110001;
  localparam logic [OPC_W-1:0] OPC_CMP   = 6'b001110;
  localparam logic [OPC_W-1:0] OPC_TEST  = 6'b001111;
  localparam logic [OPC_W-1:0] OPC_CMPI  = 6'b011110;
  localparam logic [OPC_W-1:0] OPC_TESTI = 6'b011111;

  localparam logic [2:0] REG_MASK_RS = 3'b001;
  localparam logic [2:0] REG_MASK_RT = 3'b010;
  localparam logic [2:0] REG_MASK_RD = 3'b100;

  typedef enum logic [1:0] {
    CLS_NOP = 2'd0,
    CLS_ALU = 2'd1,
    CLS_MEM = 2'd2,
    CLS_BR  = 2'd3
  } cls_e;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_HELD   = 2'd1,
    ST_BUBBLE = 2'd2
  } state_e;

endpackage

// File: rtl/dual_issue_steer_unit_inst_classifier.sv
// Combinational decode of one instruction into its issue class and the
// registers it reads (src mask over rs/rt) and writes (dst_reg when dst mask set).
module dual_issue_steer_unit_inst_classifier
  import dual_issue_steer_unit_pkg::*;
#(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned REG_LOG2   = 5
) (
  input  logic [INST_WIDTH-1:0] inst,
  output cls_e                  cls,
  output logic [2:0]            src_mask,
  output logic [2:0]            dst_mask,
  output logic [REG_LOG2-1:0]   rs,
  output logic [REG_LOG2-1:0]   rt,
  output logic [REG_LOG2-1:0]   dst_reg
);

  logic [OPC_W-1:0]    opc;
  logic [REG_LOG2-1:0] rd;

  assign opc = inst[INST_WIDTH-1 -: OPC_W];
  assign rs  = inst[INST_WIDTH-OPC_W-1 -: REG_LOG2];
  assign rt  = inst[INST_WIDTH-OPC_W-REG_LOG2-1 -: REG_LOG2];
  assign rd  = inst[INST_WIDTH-OPC_W-2*REG_LOG2-1 -: REG_LOG2];

  always_comb begin
    cls      = CLS_ALU;
    src_mask = '0;
    dst_mask = '0;
    if (inst == '0) begin
      cls = CLS_NOP;
    end else begin
      if (opc[5:4] == 2'b10) begin
        cls = CLS_MEM;
      end else if (opc[5:4] == 2'b11 || opc == OPC_CMP || opc == OPC_TEST ||
                   opc == OPC_CMPI || opc == OPC_TESTI) begin
        cls = CLS_BR;
      end
      // Specific memory/jump opcodes take precedence over the generic format rules
      if (opc == OPC_LW) begin
        src_mask = REG_MASK_RS;
        dst_mask = REG_MASK_RT;
      end else if (opc == OPC_SW) begin
        src_mask = REG_MASK_RS | REG_MASK_RT;
      end else if (opc == OPC_LA) begin
        dst_mask = REG_MASK_RT;
      end else if (opc == OPC_SA) begin
        src_mask = REG_MASK_RT;
      end else if (opc == OPC_JR) begin
        src_mask = REG_MASK_RS;
      end else if (opc[5:4] == 2'b00) begin
        src_mask = REG_MASK_RS | REG_MASK_RT;
        dst_mask = REG_MASK_RD;
      end else if (opc[5:4] == 2'b01) begin
        src_mask = REG_MASK_RS;
        dst_mask = REG_MASK_RT;
      end
    end
    dst_reg = dst_mask[2] ? rd : rt;
  end

endmodule

// File: rtl/dual_issue_steer_unit.sv
// Registered dual-issue steer unit: hazard checks, pair splitting with a one-entry
// hold buffer, load-use bubbles, flush and output backpressure.
module dual_issue_steer_unit
  import dual_issue_steer_unit_pkg::*;
#(
  parameter int unsigned INST_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned REG_LOG2        = 5,
  parameter int unsigned LOAD_USE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] in_inst0,
  input  logic [INST_WIDTH-1:0] in_inst1,
  input  logic [ADDR_WIDTH-1:0] in_pc0,
  input  logic [ADDR_WIDTH-1:0] in_pc1,
  input  logic [ID_WIDTH-1:0]   in_id0,
  input  logic [ID_WIDTH-1:0]   in_id1,
  input  logic                  ex_mem_read,
  input  logic [REG_LOG2-1:0]   ex_load_rt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] slot0_inst,
  output logic [INST_WIDTH-1:0] slot1_inst,
  output logic [ADDR_WIDTH-1:0] slot0_pc,
  output logic [ADDR_WIDTH-1:0] slot1_pc,
  output logic [ID_WIDTH-1:0]   slot0_id,
  output logic [ID_WIDTH-1:0]   slot1_id,
  output logic                  first
);

  localparam int unsigned CNT_W = 2;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rdy_q, rdy_d;
  logic                  hold_v_q, hold_v_d;
  logic [INST_WIDTH-1:0] hold_inst_q, hold_inst_d;
  logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic [ID_WIDTH-1:0]   hold_id_q, hold_id_d;
  logic                  out_valid_q, out_valid_d, first_q, first_d;
  logic [INST_WIDTH-1:0] slot0_inst_q, slot0_inst_d, slot1_inst_q, slot1_inst_d;
  logic [ADDR_WIDTH-1:0] slot0_pc_q, slot0_pc_d, slot1_pc_q, slot1_pc_d;
  logic [ID_WIDTH-1:0]   slot0_id_q, slot0_id_d, slot1_id_q, slot1_id_d;

  cls_e                c0_cls, c1_cls, ch_cls;
  logic [2:0]          c0_src, c1_src, ch_src, c0_dst, c1_dst, ch_dst;
  logic [REG_LOG2-1:0] c0_rs, c1_rs, ch_rs, c0_rt, c1_rt, ch_rt, c0_dreg, c1_dreg, ch_dreg;

  dual_issue_steer_unit_inst_classifier #(.INST_WIDTH(INST_WIDTH), .REG_LOG2(REG_LOG2)) u_cls0 (
    .inst(in_inst0), .cls(c0_cls), .src_mask(c0_src), .dst_mask(c0_dst),
    .rs(c0_rs), .rt(c0_rt), .dst_reg(c0_dreg));
  dual_issue_steer_unit_inst_classifier #(.INST_WIDTH(INST_WIDTH), .REG_LOG2(REG_LOG2)) u_cls1 (
    .inst(in_inst1), .cls(c1_cls), .src_mask(c1_src), .dst_mask(c1_dst),
    .rs(c1_rs), .rt(c1_rt), .dst_reg(c1_dreg));
  dual_issue_steer_unit_inst_classifier #(.INST_WIDTH(INST_WIDTH), .REG_LOG2(REG_LOG2)) u_clsh (
    .inst(hold_inst_q), .cls(ch_cls), .src_mask(ch_src), .dst_mask(ch_dst),
    .rs(ch_rs), .rt(ch_rt), .dst_reg(ch_dreg));

  logic hit0, hit1, hith, stall_lanes, stall_hold, out_free, raw, split, swap;

  assign hit0 = (c0_src[0] && c0_rs == ex_load_rt) || (c0_src[1] && c0_rt == ex_load_rt);
  assign hit1 = (c1_src[0] && c1_rs == ex_load_rt) || (c1_src[1] && c1_rt == ex_load_rt);
  assign hith = (ch_src[0] && ch_rs == ex_load_rt) || (ch_src[1] && ch_rt == ex_load_rt);
  assign stall_lanes = ex_mem_read && (hit0 || hit1);
  assign stall_hold  = ex_mem_read && hith;
  assign out_free    = !out_valid_q || out_ready;

  // Younger lane reads what the older lane writes; unused dst/lane1 fields are harmless
  assign raw   = (|c0_dst) && ((c1_src[0] && c1_rs == c0_dreg) || (c1_src[1] && c1_rt == c0_dreg));
  assign split = raw || (c0_cls == CLS_BR && c1_cls == CLS_BR) ||
                 (c0_cls == CLS_MEM && c1_cls == CLS_MEM);
  assign swap  = (c0_cls == CLS_MEM) || (c1_cls == CLS_BR);
  assign rdy_d = 1'b1;

  assign in_ready = rdy_q && (state_q == ST_EMPTY) && !flush && out_free && !stall_lanes;

  logic                  single_v, pair_v;
  logic [INST_WIDTH-1:0] single_inst;
  logic [ADDR_WIDTH-1:0] single_pc;
  logic [ID_WIDTH-1:0]   single_id;
  cls_e                  single_cls;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_v_d     = hold_v_q;
    hold_inst_d  = hold_inst_q;
    hold_pc_d    = hold_pc_q;
    hold_id_d    = hold_id_q;
    out_valid_d  = out_valid_q;
    first_d      = first_q;
    slot0_inst_d = slot0_inst_q;
    slot1_inst_d = slot1_inst_q;
    slot0_pc_d   = slot0_pc_q;
    slot1_pc_d   = slot1_pc_q;
    slot0_id_d   = slot0_id_q;
    slot1_id_d   = slot1_id_q;
    single_v     = 1'b0;
    pair_v       = 1'b0;
    single_inst  = in_inst0;
    single_pc    = in_pc0;
    single_id    = in_id0;
    single_cls   = c0_cls;

    if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
      first_d      = 1'b0;
      slot0_inst_d = '0;
      slot1_inst_d = '0;
      slot0_pc_d   = '0;
      slot1_pc_d   = '0;
      slot0_id_d   = '0;
      slot1_id_d   = '0;
    end

    if (flush) begin
      state_d      = ST_EMPTY;
      cnt_d        = '0;
      hold_v_d     = 1'b0;
      hold_inst_d  = '0;
      hold_pc_d    = '0;
      hold_id_d    = '0;
      out_valid_d  = 1'b0;
      first_d      = 1'b0;
      slot0_inst_d = '0;
      slot1_inst_d = '0;
      slot0_pc_d   = '0;
      slot1_pc_d   = '0;
      slot0_id_d   = '0;
      slot1_id_d   = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid && rdy_q) begin
            if (stall_lanes) begin
              state_d = ST_BUBBLE;
              cnt_d   = CNT_W'(LOAD_USE_CYCLES);
            end else if (out_free) begin
              if (split) begin
                single_v    = 1'b1;
                hold_v_d    = 1'b1;
                hold_inst_d = in_inst1;
                hold_pc_d   = in_pc1;
                hold_id_d   = in_id1;
                state_d     = ST_HELD;
              end else begin
                pair_v = 1'b1;
              end
            end
          end
        end
        ST_HELD: begin
          if (stall_hold) begin
            state_d = ST_BUBBLE;
            cnt_d   = CNT_W'(LOAD_USE_CYCLES);
          end else if (out_free) begin
            single_v    = 1'b1;
            single_inst = hold_inst_q;
            single_pc   = hold_pc_q;
            single_id   = hold_id_q;
            single_cls  = ch_cls;
            hold_v_d    = 1'b0;
            state_d     = ST_EMPTY;
          end
        end
        ST_BUBBLE: begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = hold_v_q ? ST_HELD : ST_EMPTY;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_EMPTY;
      endcase

      if (pair_v) begin
        out_valid_d  = 1'b1;
        first_d      = swap;
        slot0_inst_d = swap ? in_inst1 : in_inst0;
        slot0_pc_d   = swap ? in_pc1   : in_pc0;
        slot0_id_d   = swap ? in_id1   : in_id0;
        slot1_inst_d = swap ? in_inst0 : in_inst1;
        slot1_pc_d   = swap ? in_pc0   : in_pc1;
        slot1_id_d   = swap ? in_id0   : in_id1;
      end

      // A lone instruction goes to slot1 only if it is a memory op
      if (single_v) begin
        out_valid_d  = 1'b1;
        first_d      = (single_cls == CLS_MEM);
        slot0_inst_d = (single_cls == CLS_MEM) ? '0 : single_inst;
        slot0_pc_d   = (single_cls == CLS_MEM) ? '0 : single_pc;
        slot0_id_d   = (single_cls == CLS_MEM) ? '0 : single_id;
        slot1_inst_d = (single_cls == CLS_MEM) ? single_inst : '0;
        slot1_pc_d   = (single_cls == CLS_MEM) ? single_pc   : '0;
        slot1_id_d   = (single_cls == CLS_MEM) ? single_id   : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      cnt_q        <= '0;
      rdy_q        <= 1'b0;
      hold_v_q     <= 1'b0;
      hold_inst_q  <= '0;
      hold_pc_q    <= '0;
      hold_id_q    <= '0;
      out_valid_q  <= 1'b0;
      first_q      <= 1'b0;
      slot0_inst_q <= '0;
      slot1_inst_q <= '0;
      slot0_pc_q   <= '0;
      slot1_pc_q   <= '0;
      slot0_id_q   <= '0;
      slot1_id_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdy_q        <= rdy_d;
      hold_v_q     <= hold_v_d;
      hold_inst_q  <= hold_inst_d;
      hold_pc_q    <= hold_pc_d;
      hold_id_q    <= hold_id_d;
      out_valid_q  <= out_valid_d;
      first_q      <= first_d;
      slot0_inst_q <= slot0_inst_d;
      slot1_inst_q <= slot1_inst_d;
      slot0_pc_q   <= slot0_pc_d;
      slot1_pc_q   <= slot1_pc_d;
      slot0_id_q   <= slot0_id_d;
      slot1_id_q   <= slot1_id_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign first      = first_q;
  assign slot0_inst = slot0_inst_q;
  assign slot1_inst = slot1_inst_q;
  assign slot0_pc   = slot0_pc_q;
  assign slot1_pc   = slot1_pc_q;
  assign slot0_id   = slot0_id_q;
  assign slot1_id   = slot1_id_q;

endmodule

// File: tb/tb_dual_issue_steer_unit.sv
// Scoreboard bench for dual_issue_steer_unit: directed pairs push hand-computed
// bundles; a negedge monitor pops and compares every accepted output bundle.
module tb_dual_issue_steer_unit;

  localparam int unsigned LU = 2;

  logic        clk, rst_n, flush, in_valid, in_ready, ex_mem_read, out_valid, out_ready, first;
  logic [31:0] in_inst0, in_inst1, slot0_inst, slot1_inst;
  logic [15:0] in_pc0, in_pc1, slot0_pc, slot1_pc;
  logic [7:0]  in_id0, in_id1, slot0_id, slot1_id;
  logic [4:0]  ex_load_rt;

  dual_issue_steer_unit #(.INST_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .REG_LOG2(5),
                          .LOAD_USE_CYCLES(LU)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst0(in_inst0), .in_inst1(in_inst1), .in_pc0(in_pc0), .in_pc1(in_pc1),
    .in_id0(in_id0), .in_id1(in_id1), .ex_mem_read(ex_mem_read), .ex_load_rt(ex_load_rt),
    .out_valid(out_valid), .out_ready(out_ready), .slot0_inst(slot0_inst),
    .slot1_inst(slot1_inst), .slot0_pc(slot0_pc), .slot1_pc(slot1_pc),
    .slot0_id(slot0_id), .slot1_id(slot1_id), .first(first));

  typedef struct packed {
    logic [31:0] i0; logic [15:0] p0; logic [7:0] d0;
    logic [31:0] i1; logic [15:0] p1; logic [7:0] d1;
    logic        f;
  } bund_t;

  bund_t sb[$];
  bund_t mon_e, mon_a;
  int n_vec = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction
  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic bund_t mk(logic [31:0] i0, logic [15:0] p0, logic [7:0] d0,
                               logic [31:0] i1, logic [15:0] p1, logic [7:0] d1, logic f);
    return '{i0: i0, p0: p0, d0: d0, i1: i1, p1: p1, d1: d1, f: f};
  endfunction

  logic [31:0] ADD_3_1_2, ADDI_5_4_1, SUB_4_3_1, LW_6_1, JMP, ADD_2_7_1, CMP_1_2, SW_8_2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every transferred bundle must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_a = mk(slot0_inst, slot0_pc, slot0_id, slot1_inst, slot1_pc, slot1_id, first);
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_bundle: got s0=%h s1=%h first=%0b with empty scoreboard",
                 slot0_inst, slot1_inst, first);
      end else begin
        mon_e = sb.pop_front();
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL bundle: got s0=%h/%h/%h s1=%h/%h/%h f=%0b expected s0=%h/%h/%h s1=%h/%h/%h f=%0b",
                   mon_a.i0, mon_a.p0, mon_a.d0, mon_a.i1, mon_a.p1, mon_a.d1, mon_a.f,
                   mon_e.i0, mon_e.p0, mon_e.d0, mon_e.i1, mon_e.p1, mon_e.d1, mon_e.f);
        end
      end
    end
  end

  task automatic set_pair(input logic [31:0] i0, input logic [31:0] i1,
                          input logic [15:0] pc, input logic [7:0] id);
    in_inst0 = i0; in_inst1 = i1;
    in_pc0 = pc; in_pc1 = pc + 16'd4;
    in_id0 = id; in_id1 = id + 8'd1;
  endtask

  // Present a pair and wait (bounded) until it is accepted; returns at posedge+1
  task automatic send_pair(input logic [31:0] i0, input logic [31:0] i1,
                           input logic [15:0] pc, input logic [7:0] id);
    bit done;
    done = 1'b0;
    set_pair(i0, i1, pc, id);
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_vec++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 40 cycles, expected acceptance");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int bub;
    logic ov_seen;
    ADD_3_1_2  = enc_r(6'h00, 5'd1, 5'd2, 5'd3);
    ADDI_5_4_1 = enc_i(6'h10, 5'd4, 5'd5, 16'd1);
    SUB_4_3_1  = enc_r(6'h01, 5'd3, 5'd1, 5'd4);
    LW_6_1     = enc_i(6'h20, 5'd1, 5'd6, 16'd0);
    JMP        = enc_i(6'h30, 5'd0, 5'd0, 16'h0040);
    ADD_2_7_1  = enc_r(6'h00, 5'd7, 5'd1, 5'd2);
    CMP_1_2    = enc_r(6'h0E, 5'd1, 5'd2, 5'd0);
    SW_8_2     = enc_i(6'h21, 5'd2, 5'd8, 16'd4);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ex_mem_read = 1'b0; ex_load_rt = '0;
    set_pair('0, '0, '0, '0);

    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_slot0", slot0_inst, 0);
    chk("rst_first", first, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // Independent ALU pair, in order, one-cycle latency
    sb.push_back(mk(ADD_3_1_2, 16'h0100, 8'h10, ADDI_5_4_1, 16'h0104, 8'h11, 1'b0));
    send_pair(ADD_3_1_2, ADDI_5_4_1, 16'h0100, 8'h10);
    chk("latency_out_valid", out_valid, 1);
    drain();

    // MEM in lane0 with a branch in lane1: lanes swap
    sb.push_back(mk(JMP, 16'h0204, 8'h21, LW_6_1, 16'h0200, 8'h20, 1'b1));
    send_pair(LW_6_1, JMP, 16'h0200, 8'h20);
    drain();

    // ALU + MEM already in legal slots
    sb.push_back(mk(ADDI_5_4_1, 16'h0280, 8'h28, LW_6_1, 16'h0284, 8'h29, 1'b0));
    send_pair(ADDI_5_4_1, LW_6_1, 16'h0280, 8'h28);
    drain();

    // RAW split: ADD then SUB alone, in_ready low for exactly one cycle
    sb.push_back(mk(ADD_3_1_2, 16'h0300, 8'h30, '0, '0, '0, 1'b0));
    sb.push_back(mk(SUB_4_3_1, 16'h0304, 8'h31, '0, '0, '0, 1'b0));
    send_pair(ADD_3_1_2, SUB_4_3_1, 16'h0300, 8'h30);
    @(negedge clk);
    chk("raw_in_ready_held", in_ready, 0);
    @(negedge clk);
    chk("raw_in_ready_back", in_ready, 1);
    @(posedge clk); #1;
    drain();

    // Two branches split
    sb.push_back(mk(CMP_1_2, 16'h0400, 8'h40, '0, '0, '0, 1'b0));
    sb.push_back(mk(JMP, 16'h0404, 8'h41, '0, '0, '0, 1'b0));
    send_pair(CMP_1_2, JMP, 16'h0400, 8'h40);
    drain();

    // Two memory ops split, each alone in slot1
    sb.push_back(mk('0, '0, '0, LW_6_1, 16'h0480, 8'h48, 1'b1));
    sb.push_back(mk('0, '0, '0, SW_8_2, 16'h0484, 8'h49, 1'b1));
    send_pair(LW_6_1, SW_8_2, 16'h0480, 8'h48);
    drain();

    // Load-use: stall cycle, then LU bubble cycles, then the pair issues
    sb.push_back(mk(ADD_2_7_1, 16'h0500, 8'h50, ADDI_5_4_1, 16'h0504, 8'h51, 1'b0));
    set_pair(ADD_2_7_1, ADDI_5_4_1, 16'h0500, 8'h50);
    in_valid = 1'b1; ex_mem_read = 1'b1; ex_load_rt = 5'd7;
    @(negedge clk);
    chk("load_stall_in_ready", in_ready, 0);
    @(posedge clk); #1;
    ex_mem_read = 1'b0;
    bub = 0; ov_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (in_ready) break;
      bub++;
      ov_seen = ov_seen | out_valid;
      @(posedge clk); #1;
    end
    chk("bubble_cycles", 64'(bub), 64'(LU));
    chk("bubble_out_valid", ov_seen, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Backpressure with a held instruction, then flush drops both
    out_ready = 1'b0;
    send_pair(ADD_3_1_2, SUB_4_3_1, 16'h0600, 8'h60);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_slot0", slot0_inst, 64'(ADD_3_1_2));
      chk("bp_pc0", slot0_pc, 16'h0600);
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_slot0", slot0_inst, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("flush_no_held_issue", out_valid, 0);
    end
    @(posedge clk); #1;

    // Reset mid-run with a buffered instruction
    out_ready = 1'b0;
    send_pair(ADD_3_1_2, SUB_4_3_1, 16'h0700, 8'h70);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_slot0", slot0_inst, 0);
    chk("midrst_pc0", slot0_pc, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_release", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_buffer_empty", out_valid, 0);
    end
    @(posedge clk); #1;

    // Normal operation resumes after reset
    sb.push_back(mk(ADD_3_1_2, 16'h0800, 8'h80, ADDI_5_4_1, 16'h0804, 8'h81, 1'b0));
    send_pair(ADD_3_1_2, ADDI_5_4_1, 16'h0800, 8'h80);
    drain();

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_issue_steer_unit.md
Name: dual_issue_steer_unit

Overview:
- Registered successor to the combinational dual-issue hazard check. It sits between decode and the two issue slots.
- It accepts one fetched instruction pair per cycle through a valid/ready handshake and detects load-use and intra-pair RAW hazards.
- It steers memory ops to slot 1 and branch/compare ops to slot 0. When a pair cannot issue together, it splits the pair and holds the younger instruction in an internal buffer.
- New over the previous generation: parametrised widths, a configurable load-use bubble count, flush support, and output backpressure.

Parameters:
- INST_WIDTH, 32, instruction width.
- ADDR_WIDTH, 16, PC width.
- ID_WIDTH, 8, instruction-ID width.
- REG_LOG2, 5, register-index width.
- LOAD_USE_CYCLES, 1, bubble cycles inserted on a load-use hazard (1..3).

Ports:
- clk in 1: clock.
- rst_n in 1: asynchronous active-low reset.
- flush in 1: mispredict flush; highest priority.
- in_valid in 1: fetch pair valid.
- in_ready out 1: pair accepted when in_valid&&in_ready.
- in_inst0/in_inst1 in INST_WIDTH: pair; lane0 is older.
- in_pc0/in_pc1 in ADDR_WIDTH: PCs.
- in_id0/in_id1 in ID_WIDTH: IDs.
- ex_mem_read in 1: EX-stage instruction is a load.
- ex_load_rt in REG_LOG2: load destination.
- out_valid out 1: issue bundle valid.
- out_ready in 1: issue stage accepts the bundle.
- slot0_inst/slot1_inst out INST_WIDTH: steered instructions; 0 = NOP.
- slot0_pc/slot1_pc out ADDR_WIDTH: PCs of the steered instructions.
- slot0_id/slot1_id out ID_WIDTH: IDs of the steered instructions.
- first out 1: 1 = slot1 holds the older instruction.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; out_valid=0; first=0; in_ready=0.
  - Hold buffer empty; bubble counter 0; state EMPTY.
  - in_ready rises the first cycle after rst_n deasserts.
- Classes (inst_classifier):
  - NOP if inst==0.
  - MEM if opcode[5:4]==2'b10.
  - BR if opcode[5:4]==2'b11 or opcode is CMP/TEST/CMPI/TESTI.
  - ALU otherwise.
- Source/destination masks:
  - R-type (00xxxx): src {rs,rt}, dst rd.
  - I-type (01xxxx): src rs, dst rt.
  - LW: src rs, dst rt.
  - SW: src {rs,rt}, dst none.
  - LA: src none, dst rt.
  - SA: src rt, dst none.
  - JR: src rs.
  - Other branches and NOP: none.
- Output register:
  - All outputs are registered; latency is 1 cycle from acceptance.
  - Outputs hold while out_valid && !out_ready.
- States:
  - EMPTY: accept a pair when in_valid, no load stall, and the output register is free (!out_valid || out_ready).
  - HELD: the younger instruction of a split pair is buffered; in_ready=0. Issue it alone when the output is free → EMPTY.
  - BUBBLE: counter runs LOAD_USE_CYCLES→0 with out_valid=0 and in_ready=0, then returns to EMPTY, or to HELD if the buffer is occupied.
- Load stall:
  - Condition: ex_mem_read && (any src of the candidate == ex_load_rt). The candidate is the held instruction in HELD, else both incoming lanes.
  - Effect: enter BUBBLE; the pair is not accepted.
  - Register 0 is not special-cased.
- Split conditions (on an accepted pair):
  - the younger instruction reads the older's dst (RAW);
  - both instructions are BR;
  - both instructions are MEM.
- Split effect: the older issues alone in its legal slot (the other slot is 0), and the younger goes to the hold buffer.
- Steering of an unsplit pair:
  - MEM goes to slot1; BR goes to slot0; ALU/NOP fill the remaining slot.
  - If lanes are swapped, first=1; otherwise first=0.
- Steering of a single instruction: MEM goes to slot1; everything else goes to slot0. first=1 iff it is placed in slot1.
- Flush:
  - Next cycle: out_valid=0, all slot outputs 0, hold buffer cleared, counter cleared, state EMPTY.
  - A pair presented in the flush cycle is not accepted.
- Simultaneous events:
  - flush beats load stall; load stall beats split.
  - A held instruction is itself checked for load stall before it issues.

Decomposition:
- defines.vh: opcode/rs/rt/rd bit ranges, opcode constants (LW, SW, LA, SA, JR, CMP, TEST, CMPI, TESTI), PIPE_DONT_CARE/MEMORY/BRANCH codes, REG_MASK_RS/RT/RD, state encodings.
- Sub-module inst_classifier (combinational): inst → class, src mask, dst mask. Three instances: lane0, lane1, hold buffer.

Test Plan:
- Reset: hold rst_n=0 mid-run with a buffered instruction → all outputs 0 and buffer empty; in_ready=1 the cycle after release.
- Independent pair: ADD r3,r1,r2 + ADDI r5,r4,#1 → next cycle out_valid=1, slot0=ADD, slot1=ADDI, first=0.
- Steer swap: LW r6,0(r1) in lane0 + JMP in lane1 → slot0=JMP, slot1=LW, first=1.
- RAW split: ADD r3,r1,r2 then SUB r4,r3,r1 → cycle1: slot0=ADD only; cycle2: slot0=SUB; in_ready=0 for one cycle.
- Load-use: ex_mem_read=1, ex_load_rt=7, lane0 ADD r2,r7,r1, LOAD_USE_CYCLES=2 → 2 cycles out_valid=0, then the pair issues.
- Flush while HELD, plus backpressure: out_ready=0 for 3 cycles → outputs stable; flush → next-cycle out_valid=0, the held instruction never issues.
